spi_ram_ctrl: RTL

Command sequencer between the SPI slave front end and the single-port RAM. Gates the serial-to-parallel converter (conv_en) and decodes each 10-bit received word as {cmd[1:0], payload[7:0]}. Issues RAM write/read cycles and shifts read data back to the master on miso, MSB first. Multiple commands may be issued within one ss_n-low frame.

---
 rtl/spi_ram_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI command sequencer between slave front end and single-port RAM
module spi_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss_n,
  input  logic [DATA_WIDTH+1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  conv_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_dout_valid,
  output logic                  miso,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0]         TO_LAST  = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0]         TO_ONE   = TW'(1);
  localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]         BIT_ONE  = BW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WR    = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RD    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_WR, S_RD_REQ, S_RD_WAIT, S_TX
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;

  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  word_ok;

  assign cmd     = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = rx_data[DATA_WIDTH-1:0];
  // A word only counts when we are listening and the frame is still open
  assign word_ok = (state_q == S_RX) && rx_valid && !ss_n;

  assign conv_en  = ((state_q == S_RX) || (state_q == S_WR)) && !ss_n;
  assign busy     = (state_q != S_IDLE);
  assign miso     = (state_q == S_TX) ? shift_q[DATA_WIDTH-1] : 1'b0;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign ram_re   = ram_re_q;
  assign err      = err_q;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      err_q      <= 1'b0;
      shift_q    <= '0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      err_q      <= err_d;
      shift_q    <= shift_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Next-state decode; deselect always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (ss_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_RX;
        S_RX: begin
          if (rx_valid && cmd == CMD_WR)      state_d = S_WR;
          else if (rx_valid && cmd == CMD_RD) state_d = S_RD_REQ;
        end
        S_WR:      state_d = S_RX;
        S_RD_REQ:  state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          if (ram_dout_valid)          state_d = S_TX;
          else if (tcnt_q == TO_LAST)  state_d = S_RX;
        end
        S_TX:      if (bcnt_q == BIT_LAST) state_d = S_RX;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Strobes, address pointers, read timeout and tx shifter
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    ram_re_d   = 1'b0;
    err_d      = 1'b0;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    tcnt_d     = tcnt_q;

    if (word_ok) begin
      case (cmd)
        CMD_WADDR: wr_addr_d = payload[ADDR_WIDTH-1:0];
        CMD_RADDR: rd_addr_d = payload[ADDR_WIDTH-1:0];
        CMD_WR: begin
          ram_we_d   = 1'b1;
          ram_addr_d = wr_addr_q;
          ram_din_d  = payload;
        end
        default: begin
          ram_re_d   = 1'b1;
          ram_addr_d = rd_addr_q;
        end
      endcase
    end

    // A strobe in flight always completes, so its pointer advances even on deselect
    if (state_q == S_WR)     wr_addr_d = wr_addr_q + ADDR_ONE;
    if (state_q == S_RD_REQ) rd_addr_d = rd_addr_q + ADDR_ONE;

    if (ss_n) begin
      shift_d = '0;
      bcnt_d  = '0;
      tcnt_d  = '0;
    end else if (state_q == S_RD_WAIT) begin
      if (ram_dout_valid) begin
        shift_d = ram_dout;
        bcnt_d  = '0;
        tcnt_d  = '0;
      end else if (tcnt_q == TO_LAST) begin
        err_d  = 1'b1;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + TO_ONE;
      end
    end else if (state_q == S_TX) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      bcnt_d  = (bcnt_q == BIT_LAST) ? '0 : bcnt_q + BIT_ONE;
    end
  end

endmodule
